light_routine_gen: RTL and testbench
====================================

// Module: light_routine_gen
// PURPOSE
//  Parametrised successor of the fixed LED light routine: drives NUM_RED red and NUM_GRN green
//  LEDs with a moving bar (bounce/rotate/fill modes) plus a cascaded NUM_DIGITS seven-segment counter.
//  Internal prescaler sets step rate; Done pulses once per ROUTINE_LEN steps for the routine sequencer.
// PARAMETERS
//  NUM_RED      10  red LED count
//  NUM_GRN       8  green LED count
//  BAR_LEN       4  lit bar length, 1..min(NUM_RED,NUM_GRN)-1
//  NUM_DIGITS    4  seven-segment digits, 1..8
//  DIGIT_MOD    16  per-digit modulus, 10 (BCD) or 16 (hex)
//  PRESCALE      1  Clock cycles per step, >=1 (1 = step every enabled cycle)
//  ROUTINE_LEN  24  steps per routine period, >=2
// PORTS
//  Clock      in   1               rising-edge clock
//  Reset      in   1               synchronous, active-high reset
//  Enable     in   1               step gate; low freezes all state incl. prescaler
//  Mode       in   2               00 bounce, 01 rotate, 10 fill, 11 hold (frozen pattern)
//  LedRed     out  NUM_RED         red LED pattern, 1 = lit
//  LedGrn     out  NUM_GRN         green LED pattern, 1 = lit
//  Count      out  4*NUM_DIGITS    digit values, digit 0 in [3:0]
//  Segments   out  7*NUM_DIGITS    active-low segments {g..a} per digit, digit 0 lowest
//  Done       out  1               one-cycle pulse, last step of routine period
// BEHAVIOUR
//  Reset (Clock edge, Reset=1): prescaler=0, step count=0, Count=0, Done=0, LedGrn=BAR_LEN ones at
//   LSB end (dir up), LedRed=BAR_LEN ones at MSB end (dir down); fill-mode patterns start at 0.
//   Reset wins over Enable/Mode; mid-routine reset restarts everything same edge.
//  Step: step = Enable && prescaler==PRESCALE-1; prescaler counts 0..PRESCALE-1 while Enable, wraps.
//   All updates below occur only on the Clock edge where step=1; outputs registered, 1-cycle latency.
//  Bounce: shift bar 1 position toward current dir; when bar occupies end bit after shift, dir flips
//   for next step. Green period 2*(NUM_GRN-BAR_LEN) steps; red mirrors (starts down).
//  Rotate: circular shift (green left, red right); bar wraps across ends without change in length.
//  Fill: pattern=(p<<1)|1 (green) / (p>>1)|MSB (red); step after all-ones loads all-zeros.
//  Hold: LED patterns unchanged; Count/Done still advance.
//  Mode change: sampled at each step; if differs from previous step's mode, that step reloads the
//   reset pattern of the new mode instead of shifting; dir resets to initial.
//  Count: digit 0 +1 per step; digit k wraps DIGIT_MOD-1 -> 0 and carries to k+1; full wrap to 0.
//  Segments: combinational decode of registered Count; DIGIT_MOD=10 never shows A-F.
//  Done: registered; =1 for exactly the cycle after the step where step count==ROUTINE_LEN-1; count
//   then wraps to 0. Enable low in that following cycle does not suppress or stretch it.
//  Widths: all counters sized by $clog2, min width 1; no truncation warnings permitted.
// STRUCTURE
//  Package light_routine_pkg: Mode encodings (MODE_BOUNCE/ROTATE/FILL/HOLD), 7-seg constant table
//   (16 entries, active-low), shared by all routines.
//  Sub-module led_sweeper #(WIDTH, BAR_LEN, START_MSB): one LED channel (pattern, dir, mode reload);
//   instantiated twice (green START_MSB=0, red START_MSB=1). Digit chain/prescaler stay inline.
// TESTING
//  Defaults, Mode=00, Enable=1: green 0x0F,0x1E,0x3C,0x78,0xF0,0x78 ... ; red 0x3C0,0x1E0,... period 12.
//  Mode=01, NUM_GRN=8, BAR_LEN=4: 0xF0 -> 0xE1 -> 0xC3; red 0x00F -> 0x207.
//  Mode=10 green from reset: 0x00,0x01,0x03,...,0xFF,0x00 on successive steps.
//  DIGIT_MOD=10, 1000 steps: Count=16'h1000, Segments digit0 = 7'b1000000; 9999->0000 rollover.
//  PRESCALE=3, ROUTINE_LEN=24: Done first at cycle 72 after reset release, width 1, repeats every 72.
//  Reset asserted mid-bounce and Enable toggled randomly: post-reset state equals power-on values.

Source files
------------

// File: rtl/light_routine_pkg.sv
// Shared definitions for the LED light routine generator.
//   mode_e      : routine mode encodings driven on the Mode port
//   SEG_LUT     : active-low seven-segment patterns {g,f,e,d,c,b,a} for 0..F
//   seg_decode  : table lookup helper used by every digit decoder
package light_routine_pkg;

  typedef enum logic [1:0] {
    MODE_BOUNCE = 2'b00,
    MODE_ROTATE = 2'b01,
    MODE_FILL   = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    return SEG_LUT[digit];
  endfunction

endpackage

// File: rtl/light_routine_gen_led_sweeper.sv
// led_sweeper: one LED channel of the light routine.
//   Clock, Reset  : rising-edge clock, synchronous active-high reset
//   step          : advance the pattern this edge
//   mode_change   : mode differs from the one used on the previous step
//   mode          : current routine mode
//   pattern       : registered LED pattern, 1 = lit
// START_MSB=0 puts the bar at the LSB end moving up (rotates left, fills from
// the LSB); START_MSB=1 mirrors all of that from the MSB end.
module led_sweeper
  import light_routine_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int BAR_LEN   = 4,
  parameter bit START_MSB = 1'b0
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             step,
  input  logic             mode_change,
  input  mode_e            mode,
  output logic [WIDTH-1:0] pattern
);

  localparam logic [WIDTH-1:0] BAR_LO   = {{(WIDTH-BAR_LEN){1'b0}}, {BAR_LEN{1'b1}}};
  localparam logic [WIDTH-1:0] BAR_HI   = {{BAR_LEN{1'b1}}, {(WIDTH-BAR_LEN){1'b0}}};
  localparam logic [WIDTH-1:0] BAR_INIT = START_MSB ? BAR_HI : BAR_LO;
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MSB_ONE  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] LSB_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  // up = moving toward the MSB
  localparam logic             INIT_UP  = START_MSB ? 1'b0 : 1'b1;

  logic [WIDTH-1:0] pattern_r;
  logic             up_r;
  logic [WIDTH-1:0] shl_s;
  logic [WIDTH-1:0] shr_s;
  logic [WIDTH-1:0] nxt_pat_s;
  logic             nxt_up_s;

  // Fill starts empty; every other mode starts from the bar.
  function automatic logic [WIDTH-1:0] reload_pat(input mode_e m);
    if (m == MODE_FILL) return {WIDTH{1'b0}};
    else return BAR_INIT;
  endfunction

  // Next-pattern selection for one step.
  always_comb begin
    shl_s     = {pattern_r[WIDTH-2:0], 1'b0};
    shr_s     = {1'b0, pattern_r[WIDTH-1:1]};
    nxt_pat_s = pattern_r;
    nxt_up_s  = up_r;
    if (mode_change) begin
      nxt_pat_s = reload_pat(mode);
      nxt_up_s  = INIT_UP;
    end else begin
      case (mode)
        MODE_BOUNCE: begin
          // Direction flips once the bar has reached the end bit.
          if (up_r) begin
            nxt_pat_s = shl_s;
            nxt_up_s  = ~shl_s[WIDTH-1];
          end else begin
            nxt_pat_s = shr_s;
            nxt_up_s  = shr_s[0];
          end
        end
        MODE_ROTATE: begin
          if (START_MSB) nxt_pat_s = {pattern_r[0], pattern_r[WIDTH-1:1]};
          else           nxt_pat_s = {pattern_r[WIDTH-2:0], pattern_r[WIDTH-1]};
        end
        MODE_FILL: begin
          if (pattern_r == ALL_ONES) nxt_pat_s = {WIDTH{1'b0}};
          else if (START_MSB)        nxt_pat_s = shr_s | MSB_ONE;
          else                       nxt_pat_s = shl_s | LSB_ONE;
        end
        MODE_HOLD: nxt_pat_s = pattern_r;
        default:   nxt_pat_s = pattern_r;
      endcase
    end
  end

  // Pattern and direction registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      pattern_r <= reload_pat(mode);
      up_r      <= INIT_UP;
    end else if (step) begin
      pattern_r <= nxt_pat_s;
      up_r      <= nxt_up_s;
    end
  end

  assign pattern = pattern_r;

endmodule

// File: rtl/light_routine_gen.sv
// light_routine_gen: moving-bar LED routine with cascaded seven-segment counter.
//   Clock, Reset : rising-edge clock, synchronous active-high reset
//   Enable       : step gate, low freezes everything including the prescaler
//   Mode         : 00 bounce, 01 rotate, 10 fill, 11 hold
//   LedRed/LedGrn: registered LED patterns, 1 = lit
//   Count        : registered digit values, digit 0 in [3:0]
//   Segments     : active-low {g..a} per digit, decoded from Count
//   Done         : one-cycle pulse after the last step of each routine period
module light_routine_gen
  import light_routine_pkg::*;
#(
  parameter int NUM_RED     = 10,
  parameter int NUM_GRN     = 8,
  parameter int BAR_LEN     = 4,
  parameter int NUM_DIGITS  = 4,
  parameter int DIGIT_MOD   = 16,
  parameter int PRESCALE    = 1,
  parameter int ROUTINE_LEN = 24
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    Enable,
  input  logic [1:0]              Mode,
  output logic [NUM_RED-1:0]      LedRed,
  output logic [NUM_GRN-1:0]      LedGrn,
  output logic [4*NUM_DIGITS-1:0] Count,
  output logic [7*NUM_DIGITS-1:0] Segments,
  output logic                    Done
);

  localparam int PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int STEP_W = (ROUTINE_LEN > 1) ? $clog2(ROUTINE_LEN) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST   = PRE_W'(PRESCALE - 1);
  localparam logic [STEP_W-1:0] STEP_LAST  = STEP_W'(ROUTINE_LEN - 1);
  localparam logic [3:0]        DIGIT_LAST = 4'(DIGIT_MOD - 1);

  mode_e                   mode_s;
  mode_e                   prev_mode_r;
  logic                    mode_change_s;
  logic                    step_s;
  logic [PRE_W-1:0]        pre_r;
  logic [STEP_W-1:0]       step_cnt_r;
  logic [4*NUM_DIGITS-1:0] count_r;
  logic [4*NUM_DIGITS-1:0] count_nxt_s;
  logic                    carry_s;
  logic                    done_r;

  assign mode_s        = mode_e'(Mode);
  assign step_s        = Enable && (pre_r == PRE_LAST);
  assign mode_change_s = (mode_s != prev_mode_r);

  // Ripple-increment of the digit chain; a digit only moves when all lower digits wrap.
  always_comb begin
    count_nxt_s = count_r;
    carry_s     = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (carry_s) begin
        if (count_r[4*k +: 4] == DIGIT_LAST) begin
          count_nxt_s[4*k +: 4] = 4'd0;
        end else begin
          count_nxt_s[4*k +: 4] = count_r[4*k +: 4] + 4'd1;
          carry_s               = 1'b0;
        end
      end else begin
        count_nxt_s[4*k +: 4] = count_r[4*k +: 4];
      end
    end
  end

  // Prescaler: free-runs 0..PRESCALE-1 while enabled.
  always_ff @(posedge Clock) begin
    if (Reset)                pre_r <= {PRE_W{1'b0}};
    else if (Enable) begin
      if (pre_r == PRE_LAST)  pre_r <= {PRE_W{1'b0}};
      else                    pre_r <= pre_r + 1'b1;
    end
  end

  // Step counter, digit chain and last-seen mode advance only on a step.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      step_cnt_r  <= {STEP_W{1'b0}};
      count_r     <= {(4*NUM_DIGITS){1'b0}};
      prev_mode_r <= mode_s;
    end else if (step_s) begin
      if (step_cnt_r == STEP_LAST) step_cnt_r <= {STEP_W{1'b0}};
      else                         step_cnt_r <= step_cnt_r + 1'b1;
      count_r     <= count_nxt_s;
      prev_mode_r <= mode_s;
    end
  end

  // Done is re-evaluated every cycle so it is exactly one cycle wide regardless of Enable.
  always_ff @(posedge Clock) begin
    if (Reset) done_r <= 1'b0;
    else       done_r <= step_s && (step_cnt_r == STEP_LAST);
  end

  // Per-digit seven-segment decode of the registered count.
  always_comb begin
    Segments = {(7*NUM_DIGITS){1'b0}};
    for (int k = 0; k < NUM_DIGITS; k++) begin
      Segments[7*k +: 7] = seg_decode(count_r[4*k +: 4]);
    end
  end

  led_sweeper #(.WIDTH(NUM_GRN), .BAR_LEN(BAR_LEN), .START_MSB(1'b0)) u_grn (
    .Clock       (Clock),
    .Reset       (Reset),
    .step        (step_s),
    .mode_change (mode_change_s),
    .mode        (mode_s),
    .pattern     (LedGrn)
  );

  led_sweeper #(.WIDTH(NUM_RED), .BAR_LEN(BAR_LEN), .START_MSB(1'b1)) u_red (
    .Clock       (Clock),
    .Reset       (Reset),
    .step        (step_s),
    .mode_change (mode_change_s),
    .mode        (mode_s),
    .pattern     (LedRed)
  );

  assign Count = count_r;
  assign Done  = done_r;

endmodule

// File: tb/tb_light_routine_gen.sv
// Directed bench for light_routine_gen: a default instance for the LED modes
// and a PRESCALE=3 / BCD instance for the Done timing and digit rollover.
module tb_light_routine_gen;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic        Reset, Enable;
  logic [1:0]  Mode;
  logic [9:0]  LedRed;
  logic [7:0]  LedGrn;
  logic [15:0] Count;
  logic [27:0] Segments;
  logic        Done;

  logic        Reset2, Enable2;
  logic [1:0]  Mode2;
  logic [9:0]  LedRed2;
  logic [7:0]  LedGrn2;
  logic [15:0] Count2;
  logic [27:0] Segments2;
  logic        Done2;

  int tests_run    = 0;
  int tests_failed = 0;

  light_routine_gen u_dut (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .Mode(Mode),
    .LedRed(LedRed), .LedGrn(LedGrn), .Count(Count), .Segments(Segments), .Done(Done)
  );

  light_routine_gen #(.DIGIT_MOD(10), .PRESCALE(3), .ROUTINE_LEN(24)) u_dut2 (
    .Clock(Clock), .Reset(Reset2), .Enable(Enable2), .Mode(Mode2),
    .LedRed(LedRed2), .LedGrn(LedGrn2), .Count(Count2), .Segments(Segments2), .Done(Done2)
  );

  logic [7:0] grn_bounce [8]  = '{8'h0F, 8'h1E, 8'h3C, 8'h78, 8'hF0, 8'h78, 8'h3C, 8'h1E};
  logic [9:0] red_bounce [12] = '{10'h3C0, 10'h1E0, 10'h0F0, 10'h078, 10'h03C, 10'h01E,
                                  10'h00F, 10'h01E, 10'h03C, 10'h078, 10'h0F0, 10'h1E0};
  logic [7:0] grn_rot [7] = '{8'h1E, 8'h3C, 8'h78, 8'hF0, 8'hE1, 8'hC3, 8'h87};
  logic [9:0] red_rot [7] = '{10'h1E0, 10'h0F0, 10'h078, 10'h03C, 10'h01E, 10'h00F, 10'h207};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic check_power_on();
    check_val("por_grn",  {24'd0, LedGrn}, 32'h0F);
    check_val("por_red",  {22'd0, LedRed}, 32'h3C0);
    check_val("por_cnt",  {16'd0, Count},  32'h0);
    check_val("por_done", {31'd0, Done},   32'h0);
    check_val("por_seg",  {4'd0, Segments}, {4'd0, {4{7'h40}}});
  endtask

  logic [9:0] ones10;
  logic [7:0] ones8;
  logic [7:0] gexp;
  logic [9:0] rexp;
  int first_done;
  int done_pulses;

  initial begin
    ones10 = 10'h3FF;
    ones8  = 8'hFF;
    Reset = 1'b1; Enable = 1'b0; Mode = 2'b00;
    Reset2 = 1'b1; Enable2 = 1'b0; Mode2 = 2'b00;
    tick(); tick();
    check_power_on();

    // Bounce for one full routine period
    Reset = 1'b0; Enable = 1'b1;
    for (int n = 1; n <= 24; n++) begin
      tick();
      check_val("bounce_grn", {24'd0, LedGrn}, {24'd0, grn_bounce[n % 8]});
      check_val("bounce_red", {22'd0, LedRed}, {22'd0, red_bounce[n % 12]});
      check_val("bounce_cnt", {16'd0, Count}, n);
      check_val("bounce_done", {31'd0, Done}, {31'd0, (n == 24)});
    end
    check_val("seg_24", {4'd0, Segments}, {4'd0, 7'h40, 7'h40, 7'h79, 7'h00});

    // Enable low right after Done: no stretch, everything frozen
    Enable = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick();
      check_val("frz_done", {31'd0, Done}, 32'h0);
      check_val("frz_grn", {24'd0, LedGrn}, 32'h0F);
      check_val("frz_cnt", {16'd0, Count}, 32'd24);
    end

    // Random Enable activity mid-bounce, then reset
    for (int n = 0; n < 10; n++) begin
      Enable = 1'($urandom_range(0, 1));
      tick();
    end
    Reset = 1'b1; Enable = 1'($urandom_range(0, 1));
    tick();
    check_power_on();

    // Rotate from reset
    Mode = 2'b01;
    tick();
    Reset = 1'b0; Enable = 1'b1;
    for (int n = 0; n < 7; n++) begin
      tick();
      check_val("rot_grn", {24'd0, LedGrn}, {24'd0, grn_rot[n]});
      check_val("rot_red", {22'd0, LedRed}, {22'd0, red_rot[n]});
    end

    // Fill from reset
    Reset = 1'b1; Mode = 2'b10;
    tick();
    check_val("fill_rst_grn", {24'd0, LedGrn}, 32'h0);
    check_val("fill_rst_red", {22'd0, LedRed}, 32'h0);
    Reset = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      tick();
      gexp = (n == 9) ? 8'h00 : (ones8 >> (8 - n));
      rexp = ones10 << (10 - n);
      check_val("fill_grn", {24'd0, LedGrn}, {24'd0, gexp});
      check_val("fill_red", {22'd0, LedRed}, {22'd0, rexp});
    end

    // Mode change to bounce reloads the bar, then shifts
    Mode = 2'b00;
    tick();
    check_val("chg_grn", {24'd0, LedGrn}, 32'h0F);
    check_val("chg_red", {22'd0, LedRed}, 32'h3C0);
    tick();
    check_val("chg_grn2", {24'd0, LedGrn}, 32'h1E);
    check_val("chg_red2", {22'd0, LedRed}, 32'h1E0);

    // Hold: reload on change, then frozen while Count advances
    Mode = 2'b11;
    tick();
    check_val("hold_grn", {24'd0, LedGrn}, 32'h0F);
    tick();
    check_val("hold_grn2", {24'd0, LedGrn}, 32'h0F);
    check_val("hold_red2", {22'd0, LedRed}, 32'h3C0);
    check_val("hold_cnt", {16'd0, Count}, 32'd13);

    // Prescaled instance: Done timing
    Reset2 = 1'b0; Enable2 = 1'b1;
    first_done = 0; done_pulses = 0;
    for (int c = 1; c <= 150; c++) begin
      tick();
      if (Done2) begin
        done_pulses++;
        if (first_done == 0) first_done = c;
      end
      if (c == 73)  check_val("done_width", {31'd0, Done2}, 32'h0);
      if (c == 144) check_val("done_repeat", {31'd0, Done2}, 32'h1);
    end
    check_val("done_first", first_done, 32'd72);
    check_val("done_pulses", done_pulses, 32'd2);
    check_val("bcd_cnt_50", {16'd0, Count2}, 32'h0050);

    // BCD digit chain: 1000 steps, then 9999 -> 0000
    for (int c = 151; c <= 3000; c++) tick();
    check_val("bcd_cnt_1000", {16'd0, Count2}, 32'h1000);
    check_val("bcd_seg_d0", {25'd0, Segments2[6:0]}, 32'h40);
    check_val("bcd_seg_d3", {25'd0, Segments2[27:21]}, 32'h79);
    for (int c = 3001; c <= 29997; c++) tick();
    check_val("bcd_cnt_9999", {16'd0, Count2}, 32'h9999);
    check_val("bcd_seg_9", {25'd0, Segments2[6:0]}, 32'h10);
    for (int c = 0; c < 3; c++) tick();
    check_val("bcd_wrap", {16'd0, Count2}, 32'h0000);
    check_val("bcd_wrap_seg", {4'd0, Segments2}, {4'd0, {4{7'h40}}});

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
